// File: rtl/mxrv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mxrv_issue_ctrl_if
// Description : Bundle of the ID, EX-handshake, write-back, flush and status
//               signals that connect to the issue controller.
//               slave  modport - seen from the issue controller
//               master modport - seen from the surrounding pipeline
//   id_*_i     decoded instruction fields and use flags from ID
//   ex_ready_i EX can accept an instruction this cycle
//   wb_*_i     retiring instruction (valid, destination, wrote rd)
//   flush_i    branch/jump redirect, kills the ID instruction
//   issue_o    ID->EX transfer strobe (combinational)
//   id_stall_o hold IF/ID registers (combinational)
//   busy_o     register scoreboard, bit n = xn write pending
//   inflight_o issued but not yet retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
interface mxrv_issue_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             id_valid_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [4:0]       id_rd_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic             id_wr_rd_i;
  logic             id_serial_i;
  logic             ex_ready_i;
  logic             wb_valid_i;
  logic [4:0]       wb_rd_i;
  logic             wb_wr_i;
  logic             flush_i;
  logic             issue_o;
  logic             id_stall_o;
  logic [31:0]      busy_o;
  logic [CNT_W-1:0] inflight_o;

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i,
           id_use_rs2_i, id_wr_rd_i, id_serial_i, ex_ready_i,
           wb_valid_i, wb_rd_i, wb_wr_i, flush_i,
    output issue_o, id_stall_o, busy_o, inflight_o
  );

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i,
           id_use_rs2_i, id_wr_rd_i, id_serial_i, ex_ready_i,
           wb_valid_i, wb_rd_i, wb_wr_i, flush_i,
    input  issue_o, id_stall_o, busy_o, inflight_o
  );
endinterface
`default_nettype wire

// File: rtl/mxrv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mxrv_issue_ctrl
// Description : Issue controller between ID and EX. Keeps a 32-entry register
//               scoreboard and an in-flight counter, blocks RAW/WAW hazards,
//               drains the pipeline ahead of FENCE/CSR-class instructions and
//               discards the ID instruction on a branch flush.
// Ports       : clk    core clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    mxrv_issue_ctrl_if.slave (ID, EX, WB, flush, status)
// Revision    : 1.0 - initial release
// ============================================================================
module mxrv_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mxrv_issue_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_max_inflight = CNT_W'(MAX_INFLIGHT);

  state_t           r_state;
  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_inflight;

  logic [31:0]      w_clr_mask;
  logic [31:0]      w_set_mask;
  logic [31:0]      w_eff;
  logic             w_hazard;
  logic             w_full;
  logic             w_issue;
  logic [31:0]      w_busy_nxt;
  logic [CNT_W-1:0] w_inflight_nxt;

  // A retiring write releases its register in the same cycle; EX forwards
  // the value, so a dependent instruction may issue alongside the retire.
  assign w_clr_mask = (bus.wb_valid_i && bus.wb_wr_i) ? (32'd1 << bus.wb_rd_i) : 32'd0;
  assign w_eff      = r_busy & ~w_clr_mask;

  assign w_hazard = (bus.id_use_rs1_i & w_eff[bus.id_rs1_i])
                  | (bus.id_use_rs2_i & w_eff[bus.id_rs2_i])
                  | (bus.id_wr_rd_i   & w_eff[bus.id_rd_i]);

  assign w_full = (r_inflight == c_max_inflight) && !bus.wb_valid_i;

  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ST_RUN:    w_issue = bus.id_valid_i & ~bus.id_serial_i & ~w_hazard & ~w_full
                         & bus.ex_ready_i & ~bus.flush_i;
      ST_SERIAL: w_issue = bus.id_valid_i & bus.ex_ready_i & ~bus.flush_i;
      default:   w_issue = 1'b0;
    endcase
  end

  // Outputs are forced low while reset is asserted.
  assign bus.issue_o    = rst_n & w_issue;
  assign bus.id_stall_o = rst_n & bus.id_valid_i & ~w_issue & ~bus.flush_i;
  assign bus.busy_o     = r_busy;
  assign bus.inflight_o = r_inflight;

  // Set is applied after clear so a new writer of a retiring register wins.
  assign w_set_mask = (w_issue && bus.id_wr_rd_i) ? (32'd1 << bus.id_rd_i) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;

  // Issue and retire together leave the count unchanged; a retire with
  // nothing in flight is illegal and saturates at zero.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_issue && !bus.wb_valid_i)
      w_inflight_nxt = r_inflight + 1'b1;
    else if (!w_issue && bus.wb_valid_i && (r_inflight != '0))
      w_inflight_nxt = r_inflight - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_busy     <= 32'd0;
      r_inflight <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
      case (r_state)
        ST_RUN: begin
          if (bus.id_valid_i && bus.id_serial_i && !bus.flush_i)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.flush_i)
            r_state <= ST_RUN;
          else if ((r_inflight == '0) && !bus.wb_valid_i)
            r_state <= ST_SERIAL;
        end
        ST_SERIAL: begin
          if (w_issue || bus.flush_i)
            r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.wb_valid_i && (r_inflight == '0)))
    else $error("wb_valid_i asserted with no instruction in flight");

endmodule
`default_nettype wire

// File: tb/tb_mxrv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mxrv_issue_ctrl
// Description : Scoreboard bench for mxrv_issue_ctrl. The driver applies one
//               directed vector per cycle and queues its hand-computed
//               expected outputs; the monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mxrv_issue_ctrl;

  logic clk;
  logic rst_n;

  mxrv_issue_ctrl_if #(.CNT_W(4)) bus();

  mxrv_issue_ctrl #(
    .MAX_INFLIGHT (4),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        iss;
    logic        stl;
    logic [31:0] busy;
    logic [3:0]  inf;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_pushed = 0;

  // Driver: one vector per cycle, applied just after the rising edge.
  task automatic vec(
    input logic rn, input logic v,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic u1, input logic u2, input logic wr, input logic ser, input logic rdy,
    input logic wbv, input logic [4:0] wbrd, input logic wbwr, input logic fl,
    input logic ei, input logic es, input logic [31:0] eb, input logic [3:0] einf);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rn;
    bus.id_valid_i   = v;
    bus.id_rs1_i     = rs1;
    bus.id_rs2_i     = rs2;
    bus.id_rd_i      = rd;
    bus.id_use_rs1_i = u1;
    bus.id_use_rs2_i = u2;
    bus.id_wr_rd_i   = wr;
    bus.id_serial_i  = ser;
    bus.ex_ready_i   = rdy;
    bus.wb_valid_i   = wbv;
    bus.wb_rd_i      = wbrd;
    bus.wb_wr_i      = wbwr;
    bus.flush_i      = fl;
    e.idx  = n_pushed;
    e.iss  = ei;
    e.stl  = es;
    e.busy = eb;
    e.inf  = einf;
    q.push_back(e);
    n_pushed++;
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (bus.issue_o !== e.iss) begin
          n_miss++;
          $display("FAIL vec %0d issue_o: got %0b want %0b", e.idx, bus.issue_o, e.iss);
        end
        if (bus.id_stall_o !== e.stl) begin
          n_miss++;
          $display("FAIL vec %0d id_stall_o: got %0b want %0b", e.idx, bus.id_stall_o, e.stl);
        end
        if (bus.busy_o !== e.busy) begin
          n_miss++;
          $display("FAIL vec %0d busy_o: got %08h want %08h", e.idx, bus.busy_o, e.busy);
        end
        if (bus.inflight_o !== e.inf) begin
          n_miss++;
          $display("FAIL vec %0d inflight_o: got %0d want %0d", e.idx, bus.inflight_o, e.inf);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.id_valid_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rd_i = 0;
    bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0; bus.id_wr_rd_i = 0;
    bus.id_serial_i = 0; bus.ex_ready_i = 0; bus.wb_valid_i = 0;
    bus.wb_rd_i = 0; bus.wb_wr_i = 0; bus.flush_i = 0;

    //   rn v  rs1 rs2 rd  u1 u2 wr ser rdy wbv wrd wbw fl   iss stl busy       inf
    vec(0, 1, 0,  0,  5,  0, 0, 1, 0,  1,  0,  0,  0,  0,   0,  0,  32'h0,     0); // 0 held in reset
    vec(1, 1, 0,  0,  5,  1, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h0,     0); // 1 ADDI x5
    vec(1, 1, 5,  0,  6,  1, 1, 1, 0,  1,  0,  0,  0,  0,   0,  1,  32'h20,    1); // 2 RAW on x5
    vec(1, 1, 5,  0,  6,  1, 1, 1, 0,  1,  1,  5,  1,  0,   1,  0,  32'h20,    1); // 3 wb bypass
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  1,  6,  1,  0,   0,  0,  32'h40,    1); // 4 retire x6
    vec(1, 1, 0,  0,  0,  1, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h0,     0); // 5 write x0
    vec(1, 1, 0,  0,  0,  1, 1, 0, 0,  1,  0,  0,  0,  0,   1,  0,  32'h0,     1); // 6 read x0
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  1,  0,  1,  0,   0,  0,  32'h0,     2); // 7 retire
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  1,  0,  0,  0,   0,  0,  32'h0,     1); // 8 retire
    vec(1, 1, 0,  0,  1,  0, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h0,     0); // 9 x1
    vec(1, 1, 0,  0,  2,  0, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h2,     1); // 10 x2
    vec(1, 1, 0,  0,  3,  0, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h6,     2); // 11 x3
    vec(1, 1, 0,  0,  4,  0, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'hE,     3); // 12 x4
    vec(1, 1, 0,  0,  7,  0, 0, 1, 0,  1,  0,  0,  0,  0,   0,  1,  32'h1E,    4); // 13 full
    vec(1, 1, 0,  0,  7,  0, 0, 1, 0,  1,  1,  1,  1,  0,   1,  0,  32'h1E,    4); // 14 full + retire
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  0,  0,  0,  0,   0,  0,  32'h9C,    4); // 15 idle
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  1,  2,  1,  0,   0,  0,  32'h9C,    4); // 16 retire x2
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  1,  3,  1,  0,   0,  0,  32'h98,    3); // 17 retire x3
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  0,  0,  0,  0,   0,  1,  32'h90,    2); // 18 FENCE -> DRAIN
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  1,  4,  1,  0,   0,  1,  32'h90,    2); // 19 drain
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  1,  7,  1,  0,   0,  1,  32'h80,    1); // 20 drain
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  0,  0,  0,  0,   0,  1,  32'h0,     0); // 21 empty -> SERIAL
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  0,  0,  0,  0,   1,  0,  32'h0,     0); // 22 SERIAL issue
    vec(1, 1, 0,  0,  3,  0, 0, 1, 0,  1,  1,  0,  0,  0,   1,  0,  32'h0,     1); // 23 back in RUN
    vec(1, 1, 3,  0,  9,  1, 0, 1, 0,  1,  0,  0,  0,  0,   0,  1,  32'h8,     1); // 24 RAW stall
    vec(1, 1, 3,  0,  9,  1, 0, 1, 0,  1,  0,  0,  0,  1,   0,  0,  32'h8,     1); // 25 flush
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  0,  0,  0,  0,   0,  0,  32'h8,     1); // 26 busy kept
    vec(1, 1, 0,  0,  3,  0, 0, 1, 0,  1,  1,  3,  1,  0,   1,  0,  32'h8,     1); // 27 set vs clear
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  0,  0,  0,  0,   0,  0,  32'h8,     1); // 28 set wins
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  0,  0,  0,  0,   0,  1,  32'h8,     1); // 29 -> DRAIN
    vec(1, 1, 0,  0,  0,  0, 0, 0, 1,  1,  0,  0,  0,  1,   0,  0,  32'h8,     1); // 30 flush -> RUN
    vec(1, 1, 0,  0,  10, 0, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h8,     1); // 31 RUN issue
    vec(0, 1, 0,  0,  10, 0, 0, 1, 0,  1,  0,  0,  0,  0,   0,  0,  32'h0,     0); // 32 async reset
    vec(1, 1, 10, 0,  11, 1, 0, 1, 0,  1,  0,  0,  0,  0,   1,  0,  32'h0,     0); // 33 x10 cleared
    vec(1, 1, 0,  0,  12, 0, 0, 1, 0,  0,  0,  0,  0,  0,   0,  1,  32'h800,   1); // 34 EX not ready
    vec(1, 0, 0,  0,  0,  0, 0, 0, 0,  1,  0,  0,  0,  0,   0,  0,  32'h800,   1); // 35 idle

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mxrv_issue_ctrl.md
Name: mxrv_issue_ctrl

Overview:
Issue controller between the ID stage (mxrv_id) and the execute unit. Holds a 32-entry register scoreboard and an in-flight instruction counter, and gates each decoded instruction into EX only when its source operands are not pending a write-back. It also serialises FENCE/CSR-class instructions by draining the pipeline first, and handles branch flush. This block is the sole generator of ID-stage stall and EX-issue strobes.

Parameters:
MAX_INFLIGHT, 4, maximum number of issued but not yet written-back instructions (1..15).
CNT_W, 4, width of the in-flight counter; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  ID holds a decoded instruction
id_rs1_i  in  5  rs1 field from decode
id_rs2_i  in  5  rs2 field from decode
id_rd_i  in  5  rd field from decode
id_use_rs1_i  in  1  instruction reads rs1
id_use_rs2_i  in  1  instruction reads rs2
id_wr_rd_i  in  1  instruction writes rd
id_serial_i  in  1  FENCE/CSR: must issue with pipeline empty
ex_ready_i  in  1  EX can accept an instruction this cycle
wb_valid_i  in  1  write-back retiring one instruction
wb_rd_i  in  5  destination of retiring instruction
wb_wr_i  in  1  retiring instruction wrote rd
flush_i  in  1  branch/jump redirect; kill instruction in ID
issue_o  out  1  instruction transferred ID->EX this cycle
id_stall_o  out  1  hold IF/ID registers
busy_o  out  32  scoreboard, bit n = xn write pending
inflight_o  out  CNT_W  current in-flight count

Behaviour:
- Reset (async, rst_n=0): busy_o=0, inflight_o=0, state=RUN, issue_o=0, id_stall_o=0. Reset mid-operation discards all pending state; no write-back tracking survives.
- Scoreboard bit 0 is hardwired 0; never set.
- Effective busy eff = busy_o with bit wb_rd_i cleared when wb_valid_i&wb_wr_i (same-cycle write-back bypass, EX forwards the value).
- hazard = (id_use_rs1_i & eff[id_rs1_i]) | (id_use_rs2_i & eff[id_rs2_i]) | (id_wr_rd_i & eff[id_rd_i]) (WAW blocked).
- full = (inflight_o == MAX_INFLIGHT) and no retire this cycle.
- States: RUN, DRAIN, SERIAL.
  RUN: if id_valid_i & id_serial_i & !flush_i -> DRAIN (no issue). Else issue_o = id_valid_i & !hazard & !full & ex_ready_i & !flush_i.
  DRAIN: issue_o=0; when inflight_o==0 and no retire pending -> SERIAL. flush_i -> RUN.
  SERIAL: issue_o = id_valid_i & ex_ready_i & !flush_i; on issue or flush -> RUN.
- issue_o is combinational, same cycle as inputs (zero latency); scoreboard/counter update on the following edge.
- id_stall_o = id_valid_i & !issue_o & !flush_i.
- On issue with id_wr_rd_i & rd!=0: busy[rd] set next edge. Simultaneous retire clearing and issue setting the same register: set wins.
- inflight_o next = inflight_o + issue_o - wb_valid_i (both same cycle: unchanged). wb_valid_i with inflight_o==0 is illegal; counter saturates at 0 and is flagged by assertion.
- flush_i kills only the ID instruction; already-issued instructions still retire and clear their bits.

Test Plan:
- Reset with busy/inflight nonzero, drop rst_n between edges -> busy_o=0, inflight_o=0, state RUN immediately.
- Issue ADDI x5 (rd=5), next cycle ADD rs1=5 without wb -> issue_o=0, id_stall_o=1; assert wb_valid_i, wb_rd_i=5 -> issue_o=1 in the same cycle.
- MAX_INFLIGHT=4: issue 4 independent writes to x1..x4, ex_ready_i=1, no wb -> 5th held with id_stall_o=1, inflight_o=4; one wb -> 5th issues, inflight_o stays 4.
- FENCE (id_serial_i=1) with inflight_o=2 -> DRAIN, issue_o=0 until two wb retire; SERIAL next cycle, issue_o=1, then RUN.
- flush_i=1 with stalled ID instruction -> issue_o=0, id_stall_o=0; busy_o unchanged.
- Instruction with rd=0, id_wr_rd_i=1 issues -> busy_o bit 0 stays 0; next instruction reading x0 issues without stall.
